// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, flop macros, fetch FSM encoding and boot defaults
// for the instruction fetch front end.
`ifndef FETCH_PKG_DEFS
`define FETCH_PKG_DEFS

`define PC_WIDTH    32
`define INSTR_WIDTH 32

// Plain, reset and enabled flops; reset is synchronous and active-low.
`define FF(clk, q, d) always_ff @(posedge clk) q <= (d);
`define RST_FF(clk, rst_n, q, d, rv) always_ff @(posedge clk) if (!(rst_n)) q <= (rv); else q <= (d);
`define EN_FF(clk, rst_n, en, q, d, rv) always_ff @(posedge clk) if (!(rst_n)) q <= (rv); else if (en) q <= (d);

`endif

package fetch_pkg;

  localparam int PC_W    = `PC_WIDTH;
  localparam int INSTR_W = `INSTR_WIDTH;

  localparam logic [PC_W-1:0] BOOT_PC_DEF = 32'h0000_1000;
  localparam int              PC_INC_DEF  = 4;

  // Skid buffer depth: enough to cover one outstanding request plus one held.
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

  // Sequential PC advance; wraps naturally at the top of the address space.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc,
                                              input logic [PC_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO holding {pc, instruction} pairs between the
// memory response and decode. Flush empties it in one cycle.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int W = `PC_WIDTH + `INSTR_WIDTH
) (
  input  logic         clock,
  input  logic         reset_c,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  logic [W-1:0] r_mem [SKID_DEPTH];
  logic         r_wr_ptr, w_wr_ptr_nxt;
  logic         r_rd_ptr, w_rd_ptr_nxt;
  logic [1:0]   r_count, w_count_nxt;
  logic         w_push_ok, w_pop_ok;
  logic [1:0]   w_we;

  assign w_push_ok = i_push && (r_count != 2'd2) && !i_flush;
  assign w_pop_ok  = i_pop && (r_count != 2'd0) && !i_flush;
  assign w_we[0]   = w_push_ok && (r_wr_ptr == 1'b0);
  assign w_we[1]   = w_push_ok && (r_wr_ptr == 1'b1);

  // Pointer and occupancy update; flush wins over push and pop
  always_comb begin
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (i_flush) begin
      w_count_nxt  = 2'd0;
      w_wr_ptr_nxt = 1'b0;
      w_rd_ptr_nxt = 1'b0;
    end else begin
      if (w_push_ok) w_wr_ptr_nxt = ~r_wr_ptr;
      if (w_pop_ok)  w_rd_ptr_nxt = ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Occupancy register
  `RST_FF(clock, reset_c, r_count, w_count_nxt, 2'd0)
  // Write pointer register
  `RST_FF(clock, reset_c, r_wr_ptr, w_wr_ptr_nxt, 1'b0)
  // Read pointer register
  `RST_FF(clock, reset_c, r_rd_ptr, w_rd_ptr_nxt, 1'b0)
  // Entry 0 storage
  `EN_FF(clock, reset_c, w_we[0], r_mem[0], i_data, '0)
  // Entry 1 storage
  `EN_FF(clock, reset_c, w_we[1], r_mem[1], i_data, '0)

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/fetch_top.sv
// fetch_top: single-outstanding instruction fetch unit. Issues one memory
// request at a time, presents each instruction with its PC to decode, and
// redirects on take_branch (squashing an in-flight response if needed).
// Build option FETCH_SKID_EN: adds a 2-entry skid FIFO so fetching continues
// under stall until the FIFO fills; otherwise a single output register is
// held in the HOLD state.
module fetch_top
  import fetch_pkg::*;
#(
  parameter logic [`PC_WIDTH-1:0] BOOT_PC = BOOT_PC_DEF,
  parameter int                   PC_INC  = PC_INC_DEF
) (
  input  logic                    clock,
  input  logic                    reset_c,
  input  logic                    stall_fetch,
  input  logic                    take_branch,
  input  logic [`PC_WIDTH-1:0]    branch_pc,
  output logic                    imem_req_valid,
  output logic [`PC_WIDTH-1:0]    imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_rsp_valid,
  input  logic [`INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                    fetch_instr_valid,
  output logic [`INSTR_WIDTH-1:0] fetch_instr_data,
  output logic [`PC_WIDTH-1:0]    fetch_instr_pc
);

  localparam logic [`PC_WIDTH-1:0] PC_STEP = `PC_WIDTH'(PC_INC);

  fetch_state_t         r_state, w_state_nxt;
  logic [`PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                 r_squash, w_squash_nxt;
  logic                 w_req_allow;
  logic                 w_req_fire;
  logic                 w_rsp_hit;
  logic                 w_rsp_accept;

`ifdef FETCH_SKID_EN
  // With the skid FIFO the FSM goes straight back to REQ after a response.
  localparam fetch_state_t ST_AFTER_RSP = REQ;

  logic                                  w_buf_valid;
  logic                                  w_buf_full;
  logic                                  w_buf_pop;
  logic [`PC_WIDTH+`INSTR_WIDTH-1:0]     w_buf_head;

  assign w_req_allow = !w_buf_full;
  assign w_buf_pop   = w_buf_valid && !stall_fetch && !take_branch;

  fetch_skid_buf #(
    .W(`PC_WIDTH + `INSTR_WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset_c (reset_c),
    .i_flush (take_branch),
    .i_push  (w_rsp_accept),
    .i_data  ({r_pc, imem_rsp_data}),
    .i_pop   (w_buf_pop),
    .o_data  (w_buf_head),
    .o_valid (w_buf_valid),
    .o_full  (w_buf_full)
  );
`else
  // Without the FIFO the instruction sits in the output register in HOLD.
  localparam fetch_state_t ST_AFTER_RSP = HOLD;

  logic                    r_out_valid, w_out_valid_nxt;
  logic [`INSTR_WIDTH-1:0] r_out_data;
  logic [`PC_WIDTH-1:0]    r_out_pc;

  assign w_req_allow = 1'b1;
`endif

  // A response only counts in WAIT_RSP; squash and a same-cycle branch drop it.
  assign w_rsp_hit    = (r_state == WAIT_RSP) && imem_rsp_valid;
  assign w_rsp_accept = w_rsp_hit && !r_squash && !take_branch;
  assign w_req_fire   = (r_state == REQ) && w_req_allow && !take_branch && imem_req_ready;

  // FSM state register
  `RST_FF(clock, reset_c, r_state, w_state_nxt, IDLE)
  // Fetch PC register, loaded with the boot address on reset
  `RST_FF(clock, reset_c, r_pc, w_pc_nxt, BOOT_PC)
  // Squash flag: the in-flight response belongs to a redirected path
  `RST_FF(clock, reset_c, r_squash, w_squash_nxt, 1'b0)

  // Next state, next PC and squash; a branch overrides everything else
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_squash_nxt = r_squash;
    if (take_branch) begin
      w_pc_nxt = branch_pc;
      if ((r_state == WAIT_RSP) && !imem_rsp_valid) begin
        // The request is still in flight: wait it out and drop its data.
        w_state_nxt  = WAIT_RSP;
        w_squash_nxt = 1'b1;
      end else begin
        w_state_nxt  = REQ;
        w_squash_nxt = 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = REQ;
        end
        REQ: begin
          if (w_req_fire) w_state_nxt = WAIT_RSP;
        end
        WAIT_RSP: begin
          if (imem_rsp_valid) begin
            w_squash_nxt = 1'b0;
            if (r_squash) begin
              w_state_nxt = REQ;
            end else begin
              w_state_nxt = ST_AFTER_RSP;
              w_pc_nxt    = pc_next(r_pc, PC_STEP);
            end
          end
        end
        HOLD: begin
          if (!stall_fetch) w_state_nxt = REQ;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

`ifndef FETCH_SKID_EN
  // Output valid: set on an accepted response, cleared when consumed or redirected
  always_comb begin
    w_out_valid_nxt = r_out_valid;
    if (take_branch) begin
      w_out_valid_nxt = 1'b0;
    end else if (w_rsp_accept) begin
      w_out_valid_nxt = 1'b1;
    end else if ((r_state == HOLD) && !stall_fetch) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  // Output valid register
  `RST_FF(clock, reset_c, r_out_valid, w_out_valid_nxt, 1'b0)
  // Output instruction register
  `EN_FF(clock, reset_c, w_rsp_accept, r_out_data, imem_rsp_data, '0)
  // Output PC register: the address the accepted response was fetched from
  `EN_FF(clock, reset_c, w_rsp_accept, r_out_pc, r_pc, '0)
`endif

  // Memory request and decode-facing outputs
  always_comb begin
    imem_req_valid = (r_state == REQ) && w_req_allow && !take_branch;
    imem_req_addr  = r_pc;
`ifdef FETCH_SKID_EN
    fetch_instr_valid                  = w_buf_valid;
    {fetch_instr_pc, fetch_instr_data} = w_buf_head;
`else
    fetch_instr_valid = r_out_valid;
    fetch_instr_data  = r_out_data;
    fetch_instr_pc    = r_out_pc;
`endif
  end

endmodule

// File: tb/tb_fetch_top.sv
// tb_fetch_top: directed scenarios plus randomized stall/branch/ready/latency
// traffic against a transaction-level model of the fetch stream.
module tb_fetch_top;
  import fetch_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset_c = 1'b0;
  logic        stall_fetch = 1'b0;
  logic        take_branch = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        fetch_instr_valid;
  logic [31:0] fetch_instr_data;
  logic [31:0] fetch_instr_pc;

  fetch_top #(.BOOT_PC(BOOT), .PC_INC(4)) dut (
    .clock             (clock),
    .reset_c           (reset_c),
    .stall_fetch       (stall_fetch),
    .take_branch       (take_branch),
    .branch_pc         (branch_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .imem_req_ready    (imem_req_ready),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .fetch_instr_valid (fetch_instr_valid),
    .fetch_instr_data  (fetch_instr_data),
    .fetch_instr_pc    (fetch_instr_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] addr;
    bit          stale;
  } rsp_t;

  rsp_t        pend[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  bit          spur_en = 1'b0;
  logic [31:0] exp_pc = BOOT;
  bit          prev_held = 1'b0;
  logic [31:0] prev_data, prev_pc;
  int          n_deliv = 0;

  // Memory contents: every address holds a distinct word (0x1000 -> A000_0001).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA000_1000) + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: the delivered stream is BOOT, +4, +4 ... restarted at each
  // branch target; data is always the memory word at that PC.
  task automatic model();
    int live;
    live = 0;
    if (!reset_c) begin
      exp_pc    = BOOT;
      prev_held = 1'b0;
      foreach (pend[i]) pend[i].stale = 1'b1;
      return;
    end
    foreach (pend[i]) if (!pend[i].stale) live++;
    if (imem_req_valid) chk("one_outstanding", live, 0);
    if (imem_req_valid && imem_req_ready)
      pend.push_back('{due: cyc + mem_lat, addr: imem_req_addr, stale: 1'b0});
    if (prev_held) begin
      chk("hold_valid", fetch_instr_valid, 1'b1);
      chk("hold_data", fetch_instr_data, prev_data);
      chk("hold_pc", fetch_instr_pc, prev_pc);
    end
    if (fetch_instr_valid && !stall_fetch && !take_branch) begin
      chk("deliv_pc", fetch_instr_pc, exp_pc);
      chk("deliv_data", fetch_instr_data, mem_word(fetch_instr_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (take_branch) exp_pc = branch_pc;
    prev_held = fetch_instr_valid && stall_fetch && !take_branch;
    prev_data = fetch_instr_data;
    prev_pc   = fetch_instr_pc;
  endtask

  // One cycle: drive inputs at negedge, let them settle, then observe.
  task automatic tick(input bit stall, input bit br, input logic [31:0] bpc, input bit rdy);
    @(negedge clock);
    stall_fetch    = stall;
    take_branch    = br;
    branch_pc      = bpc;
    imem_req_ready = rdy;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else if (spur_en && pend.size() == 0 && $urandom_range(0, 7) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end
    #1;
    model();
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_c = 1'b0;
    repeat (3) tick(0, 0, '0, 1);
    chk("rst_valid", fetch_instr_valid, 1'b0);
    chk("rst_data", fetch_instr_data, 32'h0);
    chk("rst_pc", fetch_instr_pc, 32'h0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    reset_c = 1'b1;

`ifndef FETCH_SKID_EN
    // Boot fetch with a 1-cycle memory
    tick(0, 0, '0, 1);
    chk("boot_req_valid", imem_req_valid, 1'b1);
    chk("boot_req_addr", imem_req_addr, 32'h1000);
    tick(0, 0, '0, 1);
    chk("wait_no_req", imem_req_valid, 1'b0);
    tick(0, 0, '0, 1);
    chk("first_valid", fetch_instr_valid, 1'b1);
    chk("first_data", fetch_instr_data, 32'hA000_0001);
    chk("first_pc", fetch_instr_pc, 32'h1000);
    tick(0, 0, '0, 1);
    chk("seq_req_valid", imem_req_valid, 1'b1);
    chk("seq_req_addr", imem_req_addr, 32'h1004);
    chk("consumed_clears", fetch_instr_valid, 1'b0);
    tick(0, 0, '0, 1);
    // Stall three cycles while the second instruction is presented
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, '0, 1);
      chk("stall_valid", fetch_instr_valid, 1'b1);
      chk("stall_data", fetch_instr_data, mem_word(32'h1004));
      chk("stall_pc", fetch_instr_pc, 32'h1004);
      chk("stall_no_req", imem_req_valid, 1'b0);
    end
    tick(0, 0, '0, 1);
    mem_lat = 3;
    tick(0, 0, '0, 1);
    chk("rel_req_valid", imem_req_valid, 1'b1);
    chk("rel_req_addr", imem_req_addr, 32'h1008);
    // Branch while the 0x1008 response is still in flight
    tick(0, 1, 32'h2000, 1);
    tick(0, 0, '0, 1);
    chk("sq_no_req", imem_req_valid, 1'b0);
    chk("sq_no_valid", fetch_instr_valid, 1'b0);
    tick(0, 0, '0, 1);
    mem_lat = 1;
    tick(0, 0, '0, 1);
    chk("br_req_valid", imem_req_valid, 1'b1);
    chk("br_req_addr", imem_req_addr, 32'h2000);
    chk("br_drop_valid", fetch_instr_valid, 1'b0);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
    chk("br_valid", fetch_instr_valid, 1'b1);
    chk("br_pc", fetch_instr_pc, 32'h2000);
    // Memory back-pressure for four cycles
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, '0, 0);
      chk("bp_req_valid", imem_req_valid, 1'b1);
      chk("bp_req_addr", imem_req_addr, 32'h2004);
    end
    tick(0, 0, '0, 1);
    chk("bp_req_accept", imem_req_valid, 1'b1);
    tick(0, 0, '0, 1);
    chk("bp_single", imem_req_valid, 1'b0);
    tick(0, 0, '0, 1);
    chk("bp_pc", fetch_instr_pc, 32'h2004);
    // Fetch at the top of the address space wraps to zero
    tick(0, 1, 32'hFFFF_FFFC, 0);
    tick(0, 0, '0, 1);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
    chk("wrap_pc", fetch_instr_pc, 32'hFFFF_FFFC);
    tick(0, 0, '0, 1);
    chk("wrap_next_valid", imem_req_valid, 1'b1);
    chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
    // Branch in the same cycle as the response: no squash left behind
    tick(0, 1, 32'h3000, 1);
    mem_lat = 2;
    tick(0, 0, '0, 1);
    chk("same_req_valid", imem_req_valid, 1'b1);
    chk("same_req_addr", imem_req_addr, 32'h3000);
    chk("same_no_valid", fetch_instr_valid, 1'b0);
    // Reset while the 0x3000 request is outstanding
    reset_c = 1'b0;
    tick(0, 0, '0, 1);
    reset_c = 1'b1;
    mem_lat = 1;
    tick(0, 0, '0, 1);
    chk("rr_req_valid", imem_req_valid, 1'b1);
    chk("rr_req_addr", imem_req_addr, 32'h1000);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
    chk("rr_valid", fetch_instr_valid, 1'b1);
    chk("rr_data", fetch_instr_data, 32'hA000_0001);
    chk("rr_pc", fetch_instr_pc, 32'h1000);
`else
    begin
      int acc;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        tick(1, 0, '0, 1);
        if (imem_req_valid && imem_req_ready) acc++;
      end
      chk("skid_accepts", acc, 2);
      chk("skid_blocked", imem_req_valid, 1'b0);
      chk("skid_head_valid", fetch_instr_valid, 1'b1);
      tick(0, 0, '0, 1);
      chk("skid_out0_valid", fetch_instr_valid, 1'b1);
      chk("skid_out0_pc", fetch_instr_pc, 32'h1000);
      tick(0, 0, '0, 1);
      chk("skid_out1_valid", fetch_instr_valid, 1'b1);
      chk("skid_out1_pc", fetch_instr_pc, 32'h1004);
    end
`endif

    // Randomized traffic
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bpc;
      mem_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) bpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else bpc = $urandom & 32'h0000_FFFC;
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, bpc,
           $urandom_range(0, 3) != 0);
    end
    chk("progress", n_deliv >= 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
